f8_alu_seq: RTL and testbench
=============================

# f8_alu_seq

Multi-byte arithmetic sequencer for the 3850 ALU (`f8_3850_alu`, instantiated inside this block). It accepts one command at a time, walks little-endian byte strings in the 64-byte scratchpad, and drives the single-byte ALU over one to three passes per byte. Carry is chained between bytes with `ALU_LINK`. When the string is finished it reports F8-convention status flags.

## Interface
- `LEN_W`, 4: length field width; a length of 0 encodes 2^LEN_W bytes.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE; a command is accepted on any edge where valid & ready.
- `cmd_op` in 2: 0 ADD, 1 SUB, 2 INC, 3 CMP.
- `cmd_dst` in 6: LS byte address of the destination / left operand string.
- `cmd_src` in 6: LS byte address of the source / right operand string. Ignored by INC.
- `cmd_len` in LEN_W: byte count.
- `sp_addr` out 6: scratchpad address.
- `sp_rd_en` out 1: read strobe. `sp_rdata` is valid in the cycle after the strobe.
- `sp_rdata` in 8: read data.
- `sp_we` out 1: write strobe, committed at the clock edge.
- `sp_wdata` out 8: write data.
- `done` out 1: one-cycle pulse at the end of a command.
- `w_flags` out 4: {OV, Z, C, S}, in W-register bit order 3..0. Updated only with `done`.

## Operation
- Registers: `L` (dst byte), `R` (src byte), byte index `i`, running carry `cy`, running zero `zacc`, byte count.
- Initial carry `cy`:
  - ADD: 0.
  - SUB, CMP, INC: 1.
- `zacc` initialises to 1.
- Scratchpad addresses are `dst+i` and `src+i`, taken mod 64 (wrap from 0x3F to 0x00).
- Per-byte state sequence:
  - ADD: RD_D, RD_S, LATCH, ADD, LINK, WRITE.
  - SUB: RD_D, RD_S, LATCH, COMP, ADD, LINK, WRITE.
  - CMP: same as SUB with WRITE skipped; `sp_we` is never asserted.
  - INC: RD_D, LATCH, LINK, WRITE.
- State actions:
  - RD_D: `sp_rd_en=1`, `sp_addr=dst+i`.
  - RD_S: `sp_rd_en=1`, `sp_addr=src+i`; `L<=sp_rdata`.
  - LATCH: `R<=sp_rdata`. For INC, `L<=sp_rdata` instead.
  - COMP: ALU `ALU_COM` with left=R; `R<=result`.
  - ADD: ALU `ALU_ADD` with L, R; `L<=result`; capture `c1`, `ov1`.
  - LINK: ALU `ALU_LINK` with left=L, `c_in=cy`; `L<=result`; capture `c2`, `ov2`.
    - `cy<=c1|c2`.
    - `zacc<=zacc & z`.
    - On the MS byte, latch `ovm=ov1^ov2` and `sm=s`.
    - For INC, `c1=ov1=0`.
  - WRITE: `sp_we=1`, `sp_addr=dst+i`, `sp_wdata=L`.
- After the last byte the FSM enters DONE:
  - `done=1`.
  - `w_flags<={ovm, zacc, cy, sm}`.
  - Next state is IDLE.
- Flag conventions:
  - C=1 means carry out, or no borrow for SUB/CMP.
  - S=1 means MS byte bit7=0 (ALU `s`).
  - Z=1 means every result byte was 0.
- `sp_*` outputs are Moore-decoded from the state and are 0 outside the states listed above.
- A command arriving while busy is stalled (`cmd_ready=0`); it is not dropped.

## Timing
- After reset: state IDLE, `cmd_ready=1`, `done=0`, `w_flags=0`, `sp_rd_en=0`, `sp_we=0`, `sp_addr=0`, `sp_wdata=0`.
- Command accepted in cycle N: the first RD_D is in cycle N+1.
- Cycles per byte: ADD 6, SUB 7, CMP 6, INC 4. `done` is high in cycle N+len·k+1, and `cmd_ready` returns in the following cycle.
- `cmd_len=0` runs 16 bytes (at LEN_W=4).
- A command is not accepted in the DONE cycle (no back-to-back overlap).
- Reset asserted in any state:
  - FSM returns to IDLE at that edge.
  - No scratchpad access occurs in the following cycle.
  - Partially written strings stay as written.
  - `w_flags` clears; `done` is not pulsed.

## Configuration
- `F8_ALU_SEQ_CMP_EN`
  - Defined: op 3 (CMP) executes as described.
  - Undefined: op 3 is illegal. It is accepted, goes directly to DONE in cycle N+1, makes no scratchpad access, pulses `done`, and leaves `w_flags` unchanged.

## Test plan
- **ADD, signed overflow.** len=2, dst 0x10/0x11 = 0xFF/0x7F, src 0x20/0x21 = 0x01/0x00 → dst = 0x00/0x80; `w_flags` = OV1 Z0 C0 S0; `done` in cycle N+13.
- **SUB to zero.** len=1, dst=0x05, src=0x05 → dst=0x00; OV0 Z1 C1 S1; `done` at N+8.
- **INC across the wrap.** len=3, dst=0x3E with mem[0x3E]=0xFF, mem[0x3F]=0xFF, mem[0x00]=0x12 → 0x00/0x00/0x13; Z0 C0 S1; `done` at N+13.
- **CMP (macro defined).** len=1, dst=0x03, src=0x07 → `sp_we` never high, memory unchanged; C0 (borrow) Z0 S0 (0xFC).
- **Length 0.** ADD with `cmd_len=0` over 16 bytes of 0x00 + 0x00 → 16 writes of 0x00, Z1 C0, `done` at N+97.
- **Reset mid-command.** Reset in the LINK cycle of byte 1 of a len=4 ADD → IDLE next cycle, no further `sp_we`, `w_flags=0`, no `done`; a fresh command is then accepted normally.

Source files
------------

// File: rtl/f8_alu_seq.sv
// f8_alu_seq: multi-byte ADD/SUB/INC/CMP sequencer over the 64-byte scratchpad, built on the 3850 ALU.
// Define F8_ALU_SEQ_CMP_EN to execute CMP; otherwise op 3 completes immediately without touching state.
package f8_alu_pkg;
   typedef enum logic [1:0] {ALU_ADD, ALU_LINK, ALU_COM} alu_op_e;
endpackage

module f8_3850_alu
   import f8_alu_pkg::*;
(
   input  alu_op_e    op,
   input  logic [7:0] left,
   input  logic [7:0] right,
   input  logic       c_in,
   output logic [7:0] result,
   output logic       c,
   output logic       ov,
   output logic       z,
   output logic       s
);
   logic [7:0] addend;
   logic       cin;
   logic [8:0] sum;

   always_comb begin
      addend = '0;
      cin    = 1'b0;
      case (op)
         ALU_ADD:  addend = right;
         ALU_LINK: cin    = c_in;
         default:  ;
      endcase
      sum = {1'b0, left} + {1'b0, addend} + {8'b0, cin};
      if (op == ALU_COM) begin
         result = ~left;
         c      = 1'b0;
         ov     = 1'b0;
      end else begin
         result = sum[7:0];
         c      = sum[8];
         ov     = (left[7] == addend[7]) && (result[7] != left[7]);
      end
      z = (result == '0);
      s = ~result[7];
   end
endmodule

module f8_alu_seq
   import f8_alu_pkg::*;
#(
   parameter int unsigned LEN_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [5:0]       cmd_dst,
   input  logic [5:0]       cmd_src,
   input  logic [LEN_W-1:0] cmd_len,
   output logic [5:0]       sp_addr,
   output logic             sp_rd_en,
   input  logic [7:0]       sp_rdata,
   output logic             sp_we,
   output logic [7:0]       sp_wdata,
   output logic             done,
   output logic [3:0]       w_flags
);
   typedef enum logic [3:0] {
      S_IDLE, S_RD_D, S_RD_S, S_LATCH, S_COMP, S_ADD, S_LINK, S_WRITE, S_DONE
   } state_e;
   typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_INC, OP_CMP} op_e;

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [5:0]       dst_q, dst_d, src_q, src_d;
   logic [LEN_W:0]   cnt_q, cnt_d;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic [7:0]       l_q, l_d, r_q, r_d;
   logic             cy_q, cy_d, zacc_q, zacc_d;
   logic             c1_q, c1_d, ov1_q, ov1_d, ovm_q, ovm_d, sm_q, sm_d;
   logic             upd_q, upd_d;
   logic             cmd_ready_q, cmd_ready_d, done_q, done_d;
   logic [3:0]       w_flags_q, w_flags_d;
   logic             sp_rd_en_q, sp_rd_en_d, sp_we_q, sp_we_d;
   logic [5:0]       sp_addr_q, sp_addr_d;
   logic [7:0]       sp_wdata_q, sp_wdata_d;

   alu_op_e    alu_op;
   logic [7:0] alu_left, alu_res;
   logic       alu_c, alu_ov, alu_z, alu_s;
   logic       last, c1_eff, ov1_eff;

   f8_3850_alu u_alu (
      .op     (alu_op),
      .left   (alu_left),
      .right  (r_q),
      .c_in   (cy_q),
      .result (alu_res),
      .c      (alu_c),
      .ov     (alu_ov),
      .z      (alu_z),
      .s      (alu_s)
   );

   always_comb begin
      alu_op   = ALU_ADD;
      alu_left = l_q;
      case (state_q)
         S_COMP: begin
            alu_op   = ALU_COM;
            alu_left = r_q;
         end
         S_LINK:  alu_op = ALU_LINK;
         default: ;
      endcase
   end

   assign last    = ((LEN_W+1)'(idx_q) + (LEN_W+1)'(1)) == cnt_q;
   assign c1_eff  = (op_q == OP_INC) ? 1'b0 : c1_q;
   assign ov1_eff = (op_q == OP_INC) ? 1'b0 : ov1_q;

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      dst_d     = dst_q;
      src_d     = src_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      l_d       = l_q;
      r_d       = r_q;
      cy_d      = cy_q;
      zacc_d    = zacc_q;
      c1_d      = c1_q;
      ov1_d     = ov1_q;
      ovm_d     = ovm_q;
      sm_d      = sm_q;
      upd_d     = upd_q;
      w_flags_d = w_flags_q;

      case (state_q)
         S_IDLE: if (cmd_valid) begin
            op_d   = op_e'(cmd_op);
            dst_d  = cmd_dst;
            src_d  = cmd_src;
            cnt_d  = (cmd_len == '0) ? {1'b1, {LEN_W{1'b0}}} : (LEN_W+1)'(cmd_len);
            idx_d  = '0;
            cy_d   = (op_e'(cmd_op) != OP_ADD);
            zacc_d = 1'b1;
`ifdef F8_ALU_SEQ_CMP_EN
            upd_d   = 1'b1;
            state_d = S_RD_D;
`else
            upd_d   = (op_e'(cmd_op) != OP_CMP);
            state_d = (op_e'(cmd_op) == OP_CMP) ? S_DONE : S_RD_D;
`endif
         end
         S_RD_D:  state_d = (op_q == OP_INC) ? S_LATCH : S_RD_S;
         S_RD_S: begin
            l_d     = sp_rdata;
            state_d = S_LATCH;
         end
         S_LATCH: begin
            if (op_q == OP_INC) begin
               l_d     = sp_rdata;
               state_d = S_LINK;
            end else begin
               r_d     = sp_rdata;
               state_d = (op_q == OP_ADD) ? S_ADD : S_COMP;
            end
         end
         S_COMP: begin
            r_d     = alu_res;
            state_d = S_ADD;
         end
         S_ADD: begin
            l_d     = alu_res;
            c1_d    = alu_c;
            ov1_d   = alu_ov;
            state_d = S_LINK;
         end
         S_LINK: begin
            l_d    = alu_res;
            cy_d   = c1_eff | alu_c;
            zacc_d = zacc_q & alu_z;
            if (last) begin
               ovm_d = ov1_eff ^ alu_ov;
               sm_d  = alu_s;
            end
            if (op_q != OP_CMP) begin
               state_d = S_WRITE;
            end else if (last) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + LEN_W'(1);
               state_d = S_RD_D;
            end
         end
         S_WRITE: begin
            if (last) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + LEN_W'(1);
               state_d = S_RD_D;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (state_d == S_DONE && state_q != S_DONE && upd_d)
         w_flags_d = {ovm_d, zacc_d, cy_d, sm_d};

      // Outputs are registered but decoded from the next state, so they still appear in the state's own cycle.
      cmd_ready_d = (state_d == S_IDLE);
      done_d      = (state_d == S_DONE);
      sp_rd_en_d  = (state_d == S_RD_D) || (state_d == S_RD_S);
      sp_we_d     = (state_d == S_WRITE);
      sp_wdata_d  = (state_d == S_WRITE) ? l_d : '0;
      case (state_d)
         S_RD_D, S_WRITE: sp_addr_d = dst_d + 6'(idx_d);
         S_RD_S:          sp_addr_d = src_d + 6'(idx_d);
         default:         sp_addr_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         op_q        <= OP_ADD;
         dst_q       <= '0;
         src_q       <= '0;
         cnt_q       <= '0;
         idx_q       <= '0;
         l_q         <= '0;
         r_q         <= '0;
         cy_q        <= 1'b0;
         zacc_q      <= 1'b0;
         c1_q        <= 1'b0;
         ov1_q       <= 1'b0;
         ovm_q       <= 1'b0;
         sm_q        <= 1'b0;
         upd_q       <= 1'b0;
         cmd_ready_q <= 1'b1;
         done_q      <= 1'b0;
         w_flags_q   <= '0;
         sp_rd_en_q  <= 1'b0;
         sp_we_q     <= 1'b0;
         sp_addr_q   <= '0;
         sp_wdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         dst_q       <= dst_d;
         src_q       <= src_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         l_q         <= l_d;
         r_q         <= r_d;
         cy_q        <= cy_d;
         zacc_q      <= zacc_d;
         c1_q        <= c1_d;
         ov1_q       <= ov1_d;
         ovm_q       <= ovm_d;
         sm_q        <= sm_d;
         upd_q       <= upd_d;
         cmd_ready_q <= cmd_ready_d;
         done_q      <= done_d;
         w_flags_q   <= w_flags_d;
         sp_rd_en_q  <= sp_rd_en_d;
         sp_we_q     <= sp_we_d;
         sp_addr_q   <= sp_addr_d;
         sp_wdata_q  <= sp_wdata_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign done      = done_q;
   assign w_flags   = w_flags_q;
   assign sp_rd_en  = sp_rd_en_q;
   assign sp_we     = sp_we_q;
   assign sp_addr   = sp_addr_q;
   assign sp_wdata  = sp_wdata_q;
endmodule

// File: tb/tb_f8_alu_seq.sv
// Bench for f8_alu_seq: scratchpad model plus a byte-string arithmetic reference.
module tb_f8_alu_seq;
   localparam int unsigned LEN_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             cmd_valid, cmd_ready;
   logic [1:0]       cmd_op;
   logic [5:0]       cmd_dst, cmd_src;
   logic [LEN_W-1:0] cmd_len;
   logic [5:0]       sp_addr;
   logic             sp_rd_en, sp_we;
   logic [7:0]       sp_rdata = '0;
   logic [7:0]       sp_wdata;
   logic             done;
   logic [3:0]       w_flags;

   always #5 clk = ~clk;

   f8_alu_seq #(.LEN_W(LEN_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_dst   (cmd_dst),
      .cmd_src   (cmd_src),
      .cmd_len   (cmd_len),
      .sp_addr   (sp_addr),
      .sp_rd_en  (sp_rd_en),
      .sp_rdata  (sp_rdata),
      .sp_we     (sp_we),
      .sp_wdata  (sp_wdata),
      .done      (done),
      .w_flags   (w_flags)
   );

   logic [7:0]  mem     [64];
   logic [7:0]  ref_mem [64];
   logic        load_mem = 1'b0;
   int unsigned we_cnt = 0;

   always @(posedge clk) begin
      if (load_mem) mem <= ref_mem;
      else if (sp_we) mem[sp_addr] <= sp_wdata;
      if (sp_we) we_cnt <= we_cnt + 1;
      if (sp_rd_en) sp_rdata <= mem[sp_addr];
   end

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   logic [3:0]  exp_flags = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic load();
      @(negedge clk);
      load_mem = 1'b1;
      @(negedge clk);
      load_mem = 1'b0;
   endtask

   task automatic rand_fill();
      for (int i = 0; i < 64; i++) ref_mem[i] = 8'($urandom);
   endtask

   // Byte-serial big-number arithmetic; ref_mem becomes the expected scratchpad image.
   task automatic model(input int op, input int dst, input int src, input int len,
                        output int cycles, output int writes);
      int n, a, b, c, cin, t, r, sa, sb, v;
      bit z, ov, s;
      n = (len == 0) ? 16 : len;
`ifndef F8_ALU_SEQ_CMP_EN
      if (op == 3) begin
         cycles = 1;
         writes = 0;
         return;
      end
`endif
      c = (op == 0) ? 0 : 1;
      z = 1; ov = 0; s = 0;
      for (int i = 0; i < n; i++) begin
         a = int'(ref_mem[(dst + i) % 64]);
         case (op)
            0:       b = int'(ref_mem[(src + i) % 64]);
            1, 3:    b = 255 - int'(ref_mem[(src + i) % 64]);
            default: b = 0;
         endcase
         cin = c;
         t = a + b + cin;
         r = t % 256;
         c = t / 256;
         if (r != 0) z = 0;
         if (i == n - 1) begin
            sa = (a >= 128) ? a - 256 : a;
            sb = (b >= 128) ? b - 256 : b;
            v  = sa + sb + cin;
            ov = (v > 127) || (v < -128);
            s  = (r < 128);
         end
         if (op != 3) ref_mem[(dst + i) % 64] = r[7:0];
      end
      exp_flags = {ov, z, c[0], s};
      cycles = n * ((op == 0) ? 6 : (op == 1) ? 7 : (op == 2) ? 4 : 6) + 1;
      writes = (op == 3) ? 0 : n;
   endtask

   task automatic check_mem();
      for (int i = 0; i < 64; i++) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
   endtask

   task automatic run_cmd(input int op, input int dst, input int src, input int len);
      int cycles, writes, k;
      int unsigned we0;
      model(op, dst, src, len, cycles, writes);
      @(negedge clk);
      chk("ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_op    = 2'(op);
      cmd_dst   = 6'(dst);
      cmd_src   = 6'(src);
      cmd_len   = LEN_W'(len);
      we0       = we_cnt;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      k = 1;
      while (!done && k < cycles + 20) begin
         @(posedge clk); #1;
         k++;
      end
      chk("done_cycle", k, cycles);
      chk("ready_in_done", cmd_ready, 0);
      chk("flags", w_flags, exp_flags);
      @(posedge clk); #1;
      chk("done_pulse", done, 0);
      chk("ready_back", cmd_ready, 1);
      chk("write_count", we_cnt - we0, writes);
      check_mem();
   endtask

   initial begin
      int unsigned we0;
      int          a, b;
      bit          bad;
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_src = '0; cmd_len = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", cmd_ready, 1);
      chk("rst_done", done, 0);
      chk("rst_flags", w_flags, 0);
      chk("rst_rd_en", sp_rd_en, 0);
      chk("rst_we", sp_we, 0);
      chk("rst_addr", sp_addr, 0);
      chk("rst_wdata", sp_wdata, 0);
      reset = 1'b0;

      rand_fill();
      ref_mem[8'h10] = 8'hFF; ref_mem[8'h11] = 8'h7F;
      ref_mem[8'h20] = 8'h01; ref_mem[8'h21] = 8'h00;
      load();
      run_cmd(0, 'h10, 'h20, 2);
      chk("add_lo", mem[8'h10], 8'h00);
      chk("add_hi", mem[8'h11], 8'h80);
      chk("add_flags", w_flags, 4'b1000);

      ref_mem[8'h08] = 8'h05; ref_mem[8'h09] = 8'h05;
      load();
      run_cmd(1, 'h08, 'h09, 1);
      chk("sub_res", mem[8'h08], 8'h00);
      chk("sub_flags", w_flags, 4'b0111);

      ref_mem[8'h3E] = 8'hFF; ref_mem[8'h3F] = 8'hFF; ref_mem[8'h00] = 8'h12;
      load();
      run_cmd(2, 'h3E, 'h15, 3);
      chk("inc_b0", mem[8'h3E], 8'h00);
      chk("inc_b1", mem[8'h3F], 8'h00);
      chk("inc_b2", mem[8'h00], 8'h13);
      chk("inc_flags", w_flags, 4'b0001);

      ref_mem[8'h30] = 8'h03; ref_mem[8'h31] = 8'h07;
      load();
      run_cmd(3, 'h30, 'h31, 1);
      chk("cmp_dst_kept", mem[8'h30], 8'h03);
`ifdef F8_ALU_SEQ_CMP_EN
      chk("cmp_flags", w_flags, 4'b0000);
`else
      chk("cmp_flags_kept", w_flags, 4'b0001);
`endif

      for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
      load();
      run_cmd(0, 'h00, 'h10, 0);
      chk("len0_flags", w_flags, 4'b0101);

      // Reset in the LINK cycle of byte 1 (cycle N+11) of a 4-byte ADD.
      rand_fill();
      load();
      a = int'(ref_mem[8'h18]);
      b = int'(ref_mem[8'h28]);
      ref_mem[8'h18] = 8'((a + b) % 256);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_dst = 6'h18; cmd_src = 6'h28; cmd_len = LEN_W'(4);
      we0 = we_cnt;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_flags = '0;
      chk("mid_rst_ready", cmd_ready, 1);
      chk("mid_rst_we", sp_we, 0);
      chk("mid_rst_rd", sp_rd_en, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_flags", w_flags, 0);
      bad = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done || sp_we || sp_rd_en) bad = 1;
      end
      chk("mid_rst_quiet", bad, 0);
      chk("mid_rst_writes", we_cnt - we0, 1);
      check_mem();
      run_cmd(0, 'h18, 'h28, 4);

      for (int t = 0; t < 25; t++) begin
         rand_fill();
         load();
         run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 63)),
                 int'($urandom_range(0, 63)), int'($urandom_range(0, 15)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
